uart_rx: RTL and testbench

Asynchronous serial receiver, 8N1, LSB first, matching the framing of the team's `uart_tx`. It oversamples `rx_i` at the system clock, validates the start bit, samples each bit at its midpoint, and presents completed bytes on a valid/ready output with a one-byte holding register. It sits between the board RX pin and the command/stream consumer logic.

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_rx.sv | 143 ++++++++++++++
 tb/tb_uart_rx.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART framing types and constants for the receiver (and later the transmitter).
package uart_pkg;

    typedef enum logic [1:0] {
        Idle  = 2'd0,
        Start = 2'd1,
        Data  = 2'd2,
        Stop  = 2'd3
    } uart_rx_state_e;

    localparam int DataBits     = 8;
    localparam int CounterWidth = 24;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; reset value is a parameter.
module sync_2ff #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= ResetVal;
            q    <= ResetVal;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a one-byte valid/ready holding register.
// Optional stop-bit checking is enabled by defining UART_RX_FRAME_ERR_EN.
//
// state | meaning
// Idle  | line idle, waiting for rx_s low
// Start | counting to mid start bit, rejecting glitches
// Data  | sampling 8 data bits, LSB first
// Stop  | sampling stop bit, then completing the frame
module uart_rx
    import uart_pkg::*;
#(
    parameter int BaudRate  = 57600,
    parameter int ClockFreq = 100_000_000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                rx_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [DataBits-1:0] data_o,
    output logic                frame_err_o,
    output logic                overrun_o
);

    localparam int CyclesPerBaud = ClockFreq / BaudRate;
    localparam int IdxWidth      = $clog2(DataBits);
    localparam logic [CounterWidth-1:0] HalfLoad = CounterWidth'(CyclesPerBaud / 2 - 1);
    localparam logic [CounterWidth-1:0] FullLoad = CounterWidth'(CyclesPerBaud - 1);
    localparam logic [IdxWidth-1:0]     LastIdx  = IdxWidth'(DataBits - 1);

    logic                    rx_s;
    uart_rx_state_e          state_q, state_d;
    logic [CounterWidth-1:0] cnt_q, cnt_d;
    logic [IdxWidth-1:0]     idx_q, idx_d;
    logic [DataBits-1:0]     shift_q, shift_d;
    logic                    sample_stb;
    logic                    frame_done;
    logic                    stop_ok;
    logic                    frame_good;

    sync_2ff #(.ResetVal(1'b1)) u_sync_rx (
        .clk (clk_i),
        .rst (rst_i),
        .d   (rx_i),
        .q   (rx_s)
    );

    assign sample_stb = (cnt_q == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= Idle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = sample_stb ? cnt_q : cnt_q - CounterWidth'(1);
        idx_d      = idx_q;
        shift_d    = shift_q;
        frame_done = 1'b0;
        case (state_q)
            Idle: begin
                if (!rx_s) begin
                    cnt_d   = HalfLoad;
                    state_d = Start;
                end
            end
            Start: begin
                if (sample_stb) begin
                    if (rx_s) begin
                        state_d = Idle;
                    end else begin
                        cnt_d   = FullLoad;
                        idx_d   = '0;
                        state_d = Data;
                    end
                end
            end
            Data: begin
                if (sample_stb) begin
                    shift_d = {rx_s, shift_q[DataBits-1:1]};
                    cnt_d   = FullLoad;
                    if (idx_q == LastIdx) begin
                        state_d = Stop;
                    end else begin
                        idx_d = idx_q + IdxWidth'(1);
                    end
                end
            end
            Stop: begin
                // Returning to Idle here lets a start bit follow the stop bit directly.
                if (sample_stb) begin
                    frame_done = 1'b1;
                    state_d    = Idle;
                end
            end
            default: state_d = Idle;
        endcase
    end

`ifdef UART_RX_FRAME_ERR_EN
    assign stop_ok = rx_s;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_err_o <= 1'b0;
        end else begin
            frame_err_o <= frame_done && !rx_s;
        end
    end
`else
    assign stop_ok     = 1'b1;
    assign frame_err_o = 1'b0;
`endif

    assign frame_good = frame_done && stop_ok;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o   <= 1'b0;
            data_o    <= '0;
            overrun_o <= 1'b0;
        end else begin
            overrun_o <= frame_good && valid_o && !ready_i;
            if (frame_good && (!valid_o || ready_i)) begin
                data_o  <= shift_q;
                valid_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at C = 10 clocks per bit; follows UART_RX_FRAME_ERR_EN if defined.
module tb_uart_rx;
    import uart_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       rx_i = 1'b1;
    logic       ready_i = 1'b1;
    logic       valid_o;
    logic [7:0] data_o;
    logic       frame_err_o;
    logic       overrun_o;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_pop_cyc = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    logic [7:0] exp_q[$];

    uart_rx #(.BaudRate(100_000), .ClockFreq(1_000_000)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_i        (rx_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one frame from a negedge; the line is left at the stop level.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_i = frame[i];
            repeat (10) @(negedge clk_i);
        end
    endtask

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (frame_err_o) ferr_cnt++;
            if (overrun_o) ovr_cnt++;
            if (valid_o && ready_i) begin
                last_pop_cyc = cyc;
                if (exp_q.size() == 0) chk("unexpected_byte", {24'h0, data_o}, 32'hFFFF_FFFF);
                else chk("data", {24'h0, data_o}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        int t_fall;
        int lat;

        repeat (3) @(negedge clk_i);
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_ferr", frame_err_o, 0);
        chk("rst_ovr", overrun_o, 0);
        rst_i = 1'b0;
        repeat (5) @(negedge clk_i);

        // single byte, latency
        t_fall = cyc;
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1);
        repeat (5) @(negedge clk_i);
        lat = last_pop_cyc - t_fall;
        chk("latency_in_window", (lat >= 97 && lat <= 100), 1);
        chk("q_empty_a5", exp_q.size(), 0);
        chk("no_ferr_a5", ferr_cnt, 0);
        chk("no_ovr_a5", ovr_cnt, 0);

        // back-to-back
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        repeat (5) @(negedge clk_i);
        chk("q_empty_b2b", exp_q.size(), 0);

        // glitch then real frame
        rx_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (15) @(negedge clk_i);
        chk("glitch_idle", 32'(dut.state_q), 32'(Idle));
        chk("glitch_no_valid", valid_o, 0);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        repeat (5) @(negedge clk_i);
        chk("q_empty_3c", exp_q.size(), 0);

        // holding register full -> overrun
        @(posedge clk_i); #1 ready_i = 1'b0;
        @(negedge clk_i);
        exp_q.push_back(8'h11);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (5) @(negedge clk_i);
        chk("hold_valid", valid_o, 1);
        chk("hold_data", data_o, 8'h11);
        chk("overrun_once", ovr_cnt, 1);
        @(posedge clk_i); #1 ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("valid_falls", valid_o, 0);
        chk("q_empty_11", exp_q.size(), 0);

        // stop bit forced low
`ifndef UART_RX_FRAME_ERR_EN
        exp_q.push_back(8'h5A);
`endif
        send_byte(8'h5A, 1'b0);
        rx_i = 1'b1;
        repeat (20) @(negedge clk_i);
`ifdef UART_RX_FRAME_ERR_EN
        chk("ferr_once", ferr_cnt, 1);
`else
        chk("ferr_none", ferr_cnt, 0);
`endif
        chk("q_empty_5a", exp_q.size(), 0);
        chk("ovr_unchanged", ovr_cnt, 1);

        // reset during data bit 4
        rx_i = 1'b0;
        repeat (10) @(negedge clk_i);
        for (int i = 0; i < 4; i++) begin
            rx_i = i[0];
            repeat (10) @(negedge clk_i);
        end
        rx_i = 1'b1;
        repeat (5) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("midrst_valid", valid_o, 0);
        chk("midrst_data", data_o, 0);
        chk("midrst_ferr", frame_err_o, 0);
        chk("midrst_ovr", overrun_o, 0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (10) @(negedge clk_i);
        exp_q.push_back(8'hC3);
        send_byte(8'hC3, 1'b1);
        repeat (5) @(negedge clk_i);
        chk("q_empty_c3", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
